useq_call_stack: RTL and testbench
==================================

// Module: useq_call_stack
//
// PURPOSE
//   Parametrised microsequencer call/return stack, next generation of the single-depth-fixed
//   12-bit call stack. Pushes the return address on microcode CALL and pops it on RET.
//   Adds clock-enable qualification, occupancy count, full/empty flags, sticky overflow and
//   underflow error flags, and defined simultaneous CALL+RET behaviour.
//   Sits between the microcode dispatch logic and the next-address mux in the useq.
//
// PARAMETERS
//   AW     12  address width (bits of microcode address stored per entry)
//   DEPTH  16  number of stack entries; power of two, >= 2
//   PW     $clog2(DEPTH)  pointer width (derived localparam, not overridable)
//
// PORTS
//   clk        in   1       system clock; all state changes on rising edge
//   rst_n      in   1       reset, asynchronous, active-low
//   clken      in   1       clock enable; call/ret/clr_err are ignored when low
//   call       in   1       push addr_in (qualified by clken)
//   ret        in   1       pop top of stack (qualified by clken)
//   clr_err    in   1       clear sticky overflow/underflow (qualified by clken)
//   addr_in    in   AW      return address to push
//   addr_out   out  AW      registered top-of-stack (TOS) value
//   count      out  PW+1    occupancy, 0..DEPTH
//   empty      out  1       count == 0
//   full       out  1       count == DEPTH
//   overflow   out  1       sticky: CALL issued while full
//   underflow  out  1       sticky: RET issued while empty
//
// BEHAVIOUR
//   - Reset (rst_n low, async): sp=0, count=0, addr_out=0, overflow=0, underflow=0, empty=1,
//     full=0. RAM contents not reset. Deassertion is synchronised externally.
//   - Storage: TOS held in addr_out register; entries below TOS held in a DEPTH-entry
//     circular RAM indexed by sp (sp = next free slot; wraps modulo DEPTH).
//   - clken low: no state changes at all; outputs hold.
//   - Effective op (clken high), evaluated at the rising edge:
//       call & !ret : if count>0, RAM[sp]<=addr_out, sp<=sp+1. addr_out<=addr_in.
//                     count<=count+1 if not full. If full: count holds at DEPTH, the
//                     oldest entry is silently overwritten (circular), overflow<=1.
//       ret & !call : if count>1, addr_out<=RAM[sp-1], sp<=sp-1, count<=count-1.
//                     if count==1, addr_out<=0, count<=0, sp unchanged.
//                     if count==0, no pointer/count change, addr_out stays 0, underflow<=1.
//       call & ret  : replace TOS: addr_out<=addr_in; sp, count unchanged. If count==0 this
//                     is a push (count<=1) and underflow is NOT set. Never sets overflow.
//       neither     : no change.
//   - Latency: addr_out reflects the op one cycle after the enabled edge. A RET consumes the
//     addr_out value visible in the same cycle it is asserted (no read bubble).
//   - Back-to-back ops on consecutive enabled cycles are supported with no stall.
//   - clr_err: clears overflow and underflow; if set in the same cycle as a new error, the new
//     error wins (flag ends 1).
//   - count/empty/full are registered, consistent with addr_out every cycle.
//   - Pointer arithmetic is PW-bit and wraps; count is PW+1 bits and saturates at 0 and DEPTH.
//   - Reset asserted mid-sequence returns to the reset state immediately; the stack is empty
//     on the first enabled edge after release.
//   - RAM is single-write, single asynchronous read (distributed RAM); write only on push.
//
// TESTING
//   1 reset -> addr_out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
//   2 CALL 12'o0100, 12'o0200, 12'o0300 then RET x3 -> addr_out 0300,0200,0100,0; empty=1.
//   3 DEPTH+1 CALLs of 1..17 (DEPTH=16) -> full=1, overflow=1, count=16; 16 RETs give 17..2.
//   4 RET on empty -> underflow=1, count=0, addr_out=0; clr_err -> underflow=0.
//   5 CALL 0o0500 then CALL+RET 0o0700 -> addr_out=0o0700, count=1; RET -> empty.
//   6 clken=0 with call/ret/clr_err toggling -> no change; async rst_n pulse mid-push -> reset.

Source files
------------

// File: rtl/useq_call_stack.sv
// Microsequencer call/return stack: registered TOS over a circular RAM.
// Tracks occupancy and flags sticky overflow/underflow errors.
module useq_call_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clken,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    input  logic [AW-1:0]              addr_in,
    output logic [AW-1:0]              addr_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] SP_ONE  = PW'(1);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_sp;
    logic [PW:0]   r_count;
    logic [AW-1:0] r_tos;
    logic          r_ovf;
    logic          r_udf;

    logic          w_call;
    logic          w_ret;
    logic          w_both;
    logic          w_full;
    logic          w_empty;
    logic          w_spill;
    logic [PW-1:0] w_sp_m1;

    assign w_call  = clken & call & ~ret;
    assign w_ret   = clken & ret & ~call;
    assign w_both  = clken & call & ret;
    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == '0);
    assign w_spill = w_call & ~w_empty;
    assign w_sp_m1 = r_sp - SP_ONE;

    // Old TOS spills into the RAM only when a real entry is being pushed down.
    always_ff @(posedge clk) begin
        if (w_spill) begin
            r_mem[r_sp] <= r_tos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= '0;
            r_count <= '0;
            r_tos   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (clken && clr_err) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
            if (w_call) begin
                r_tos <= addr_in;
                if (w_spill) begin
                    r_sp <= r_sp + SP_ONE;
                end
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_ONE;
                end
            end else if (w_ret) begin
                if (r_count > CNT_ONE) begin
                    r_tos   <= r_mem[w_sp_m1];
                    r_sp    <= w_sp_m1;
                    r_count <= r_count - CNT_ONE;
                end else if (r_count == CNT_ONE) begin
                    r_tos   <= '0;
                    r_count <= '0;
                end else begin
                    r_udf <= 1'b1;
                end
            end else if (w_both) begin
                r_tos <= addr_in;
                if (w_empty) begin
                    r_count <= CNT_ONE;
                end
            end
        end
    end

    assign addr_out  = r_tos;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_useq_call_stack.sv
// Directed bench for useq_call_stack.
// Hand-computed expectations for push/pop, wrap, errors and enable.
module tb_useq_call_stack;

    logic        clk;
    logic        rst_n;
    logic        clken;
    logic        call;
    logic        ret;
    logic        clr_err;
    logic [11:0] addr_in;
    logic [11:0] addr_out;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int n_cmp;
    int n_bad;

    useq_call_stack #(.AW(12), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clken     (clken),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .addr_in   (addr_in),
        .addr_out  (addr_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic r, input logic e,
                        input logic [11:0] a, input logic ce);
        @(negedge clk);
        clken   = ce;
        call    = c;
        ret     = r;
        clr_err = e;
        addr_in = a;
        @(posedge clk);
        #1;
        call    = 1'b0;
        ret     = 1'b0;
        clr_err = 1'b0;
        clken   = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [11:0] a,
                           input logic [4:0] c, input logic e,
                           input logic f, input logic o, input logic u);
        chk({tag, ".addr"}, 32'(addr_out), 32'(a));
        chk({tag, ".cnt"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".ovf"}, 32'(overflow), 32'(o));
        chk({tag, ".udf"}, 32'(underflow), 32'(u));
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        clken   = 1'b1;
        call    = 1'b0;
        ret     = 1'b0;
        clr_err = 1'b0;
        addr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b0, 12'o0100, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'o0200, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'o0300, 1'b1);
        chk_all("c3", 12'o0300, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("r1", 12'o0200, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("r2", 12'o0100, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("r3", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 12'(i), 1'b1);
        end
        chk_all("c15", 12'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'd16, 1'b1);
        chk_all("c16", 12'd16, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'd17, 1'b1);
        chk_all("c17", 12'd17, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pop%0d", i), 32'(addr_out), 32'(17 - i));
            step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        end
        chk_all("drain", 12'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 12'd0, 1'b1);
        chk_all("clr_ovf", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("udf", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 12'd0, 1'b1);
        chk_all("clr_udf", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 12'd0, 1'b1);
        chk("udf_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 12'd0, 1'b1);
        chk("udf_clr2", 32'(underflow), 32'd0);

        step(1'b1, 1'b0, 1'b0, 12'o0500, 1'b1);
        step(1'b1, 1'b1, 1'b0, 12'o0700, 1'b1);
        chk_all("repl", 12'o0700, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("repl_ret", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'o0444, 1'b1);
        chk_all("both_emp", 12'o0444, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'o1234, 1'b1);
        chk_all("push2", 12'o1234, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b1, 12'o7777, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 12'o7070, 1'b0);
        chk_all("noen", 12'o1234, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("en_ret", 12'o0444, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        clken   = 1'b1;
        call    = 1'b1;
        addr_in = 12'o0055;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("arst_hold", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        call  = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 12'o0066, 1'b1);
        chk_all("post_rst", 12'o0066, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'd0, 1'b1);
        chk_all("post_ret", 12'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
